// File: rtl/mapache64.sv
// Shared mapache64 types, plus the VRAM arbiter's grant encoding and write-entry layout.
package mapache64;

    typedef logic [11:0] vram_address_t;
    typedef logic [7:0]  data_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        RENDER = 2'd1,
        CPU    = 2'd2
    } vram_grant_e;

    typedef struct packed {
        vram_address_t address;
        data_t         data;
    } vram_write_t;

endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous FIFO of pending CPU VRAM writes with a sticky overflow flag.
module vram_write_fifo
    import mapache64::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  vram_write_t push_data,
    input  logic        pop,
    output vram_write_t head,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    vram_write_t      mem_r [DEPTH];
    logic             do_pop_s;
    logic             do_push_s;

    // The extra pointer MSB separates "full" from "empty" when the indices match.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                       (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign head      = mem_r[rd_ptr_r[IDX_W-1:0]];

    // Pointer and overflow state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (push && !do_push_s) begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: renderer reads vs. FIFO-buffered CPU writes.
// Optional starvation guard enabled by defining VRAM_ARBITER_STARVATION_GUARD_EN.
module vram_arbiter
    import mapache64::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic          gpu_clk,
    input  logic          rst,
    input  logic          in_vblank_i,
    input  logic          cpu_write_valid_i,
    input  vram_address_t cpu_address_i,
    input  data_t         cpu_data_i,
    input  logic          render_req_i,
    input  vram_address_t render_address_i,
    output logic          render_gnt_o,
    output logic          render_rvalid_o,
    output data_t         render_rdata_o,
    output logic          vram_en_o,
    output logic          vram_we_o,
    output vram_address_t vram_address_o,
    output data_t         vram_wdata_o,
    input  data_t         vram_rdata_i,
    output logic          fifo_full_o,
    output logic          fifo_empty_o,
    output logic          overflow_o
);

    vram_grant_e   grant_s;
    vram_grant_e   grant_q;
    vram_write_t   push_entry_s;
    vram_write_t   head_s;
    logic          fifo_empty_s;
    logic          force_cpu_s;
    vram_address_t last_addr_r;
    data_t         last_wdata_r;

    assign push_entry_s = '{address: cpu_address_i, data: cpu_data_i};

    vram_write_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (gpu_clk),
        .rst       (rst),
        .push      (cpu_write_valid_i),
        .push_data (push_entry_s),
        .pop       (grant_s == CPU),
        .head      (head_s),
        .full      (fifo_full_o),
        .empty     (fifo_empty_s),
        .overflow  (overflow_o)
    );

    assign fifo_empty_o = fifo_empty_s;

`ifdef VRAM_ARBITER_STARVATION_GUARD_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt_r;

    assign force_cpu_s = !fifo_empty_s && (wait_cnt_r == WAIT_W'(MAX_WAIT));

    // Count consecutive cycles a pending write is denied the port.
    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= '0;
        end else if (fifo_empty_s || (grant_s == CPU)) begin
            wait_cnt_r <= '0;
        end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end
    end
`else
    // MAX_WAIT only matters with the guard present.
    logic unused_max_wait_s;
    assign unused_max_wait_s = ^(32'(MAX_WAIT));
    assign force_cpu_s       = 1'b0;
`endif

    // Grant decision: vblank favours the CPU, active display favours the renderer.
    always_comb begin
        grant_s = NONE;
        if (force_cpu_s) begin
            grant_s = CPU;
        end else if (in_vblank_i) begin
            if (!fifo_empty_s) begin
                grant_s = CPU;
            end else if (render_req_i) begin
                grant_s = RENDER;
            end else begin
                grant_s = NONE;
            end
        end else begin
            if (render_req_i) begin
                grant_s = RENDER;
            end else if (!fifo_empty_s) begin
                grant_s = CPU;
            end else begin
                grant_s = NONE;
            end
        end
    end

    // Port drive; address and data hold their last values on idle cycles.
    always_comb begin
        vram_address_o = last_addr_r;
        vram_wdata_o   = last_wdata_r;
        case (grant_s)
            CPU: begin
                vram_address_o = head_s.address;
                vram_wdata_o   = head_s.data;
            end
            RENDER: begin
                vram_address_o = render_address_i;
                vram_wdata_o   = last_wdata_r;
            end
            default: begin
                vram_address_o = last_addr_r;
                vram_wdata_o   = last_wdata_r;
            end
        endcase
    end

    assign vram_en_o       = (grant_s != NONE);
    assign vram_we_o       = (grant_s == CPU);
    assign render_gnt_o    = (grant_s == RENDER);
    assign render_rvalid_o = (grant_q == RENDER);
    assign render_rdata_o  = vram_rdata_i;

    // Remember the grant for read-data valid and the last driven address/data.
    always_ff @(posedge gpu_clk or posedge rst) begin
        if (rst) begin
            grant_q      <= NONE;
            last_addr_r  <= '0;
            last_wdata_r <= '0;
        end else begin
            grant_q <= grant_s;
            if (grant_s != NONE) begin
                last_addr_r <= vram_address_o;
            end
            if (grant_s == CPU) begin
                last_wdata_r <= vram_wdata_o;
            end
        end
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port synchronous VRAM between the GPU renderer's read requests and buffered CPU writes. It sits between the address decoder's VRAM write path and the VRAM macros inside the GPU, on `gpu_clk`. CPU writes are queued in a small FIFO and drained whenever the renderer does not own the port. A starvation guard can bound the CPU write wait time during active display.

## Interface
- `FIFO_DEPTH`, default 4: number of CPU write entries; must be a power of two, ≥2.
- `MAX_WAIT`, default 15: maximum number of consecutive cycles a non-empty FIFO may be denied before a forced CPU grant (guard build only).
- `gpu_clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_vblank_i`  in  1  high during vertical blank; gives the CPU priority.
- `cpu_write_valid_i`  in  1  one-cycle pulse; pushes a CPU write.
- `cpu_address_i`  in  `vram_address_t` (12)  CPU write address.
- `cpu_data_i`  in  `data_t` (8)  CPU write data.
- `render_req_i`  in  1  renderer read request, level-held until granted.
- `render_address_i`  in  12  renderer read address.
- `render_gnt_o`  out  1  renderer request accepted this cycle.
- `render_rvalid_o`  out  1  `render_rdata_o` valid; asserted one cycle after `render_gnt_o`.
- `render_rdata_o`  out  8  read data, passed through from `vram_rdata_i`.
- `vram_en_o`, `vram_we_o`  out  1 each  VRAM port enable and write enable.
- `vram_address_o`  out  12  VRAM port address.
- `vram_wdata_o`  out  8  VRAM write data.
- `vram_rdata_i`  in  8  VRAM read data; arrives one cycle after the enabled read.
- `fifo_full_o`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `fifo_empty_o`  out  1  FIFO holds no entries.
- `overflow_o`  out  1  sticky: a push was dropped.

## Operation
- Grant decision is combinational each cycle and yields exactly one of NONE, RENDER or CPU. It is registered into `grant_q` only to generate `render_rvalid_o`.
- Priority during active display (`in_vblank_i`=0): RENDER if `render_req_i`, else CPU if the FIFO is non-empty, else NONE.
- Priority during vblank: CPU if the FIFO is non-empty, else RENDER if `render_req_i`, else NONE.
- A CPU grant pops the FIFO head and drives `vram_we_o`=1 with the head's address and data.
- A RENDER grant drives `vram_we_o`=0 with `render_address_i` and asserts `render_gnt_o`.
- A NONE grant drives `vram_en_o`=0 and `vram_we_o`=0. Address and data outputs then hold their last values.
- FIFO push when not full: the entry is stored.
- FIFO push when full with no pop in the same cycle: the entry is dropped and `overflow_o` is set. Only `rst` clears `overflow_o`.
- Push and pop in the same cycle when full: the pop takes effect first and the push is accepted; the level is unchanged.
- A push into an empty FIFO is not eligible for grant until the next cycle; there is no bypass path.
- Writes drain strictly in order. Renderer reads are not checked against pending writes; software orders coherency by writing in vblank.

## Timing
- Request to grant latency: 0 cycles. Grant to `render_rvalid_o`: 1 cycle.
- A CPU write reaches VRAM no earlier than 1 cycle after its push.
- Reset values:
  - All outputs 0, except `fifo_empty_o`=1.
  - FIFO pointers 0, `grant_q`=NONE, wait counter 0.
- Reset asserted mid-operation: FIFO contents are discarded, and a `render_rvalid_o` that was pending is suppressed.
- Pointers are `$clog2(FIFO_DEPTH)+1` bits wide; the extra MSB distinguishes full from empty. They wrap modulo 2·`FIFO_DEPTH`.

## Configuration
- `VRAM_ARBITER_STARVATION_GUARD_EN` defined:
  - A wait counter of width `$clog2(MAX_WAIT+1)` increments each cycle in which the FIFO is non-empty and the grant is not CPU.
  - When the counter equals `MAX_WAIT`, the next cycle is forced to CPU even if `render_req_i` is high; `render_gnt_o` stays 0 in that cycle.
  - The counter clears on any CPU grant or when the FIFO is empty.
- Macro not defined: no counter exists, and active-display priority is pure renderer-first.

## Structure
- Package `mapache64`: reuse `vram_address_t` and `data_t`.
- Add to `mapache64`: `vram_grant_e` enum with values NONE, RENDER, CPU.
- Add to `mapache64`: `vram_write_t` struct of {address, data}.
- One sub-module, `vram_write_fifo`:
  - Parameterised synchronous FIFO of `vram_write_t`.
  - Ports: push, pop, head, full, empty, overflow.

## Test plan
- Reset, then push 3 writes (0x010←0xAA, 0x011←0xBB, 0x012←0xCC) with `render_req_i`=0 → VRAM writes occur on 3 consecutive cycles, in order, starting 1 cycle after the first push; `fifo_empty_o` returns to 1.
- `render_req_i` held high with address 0x200 and `vram_rdata_i` driven to 0x5A → `render_gnt_o` every cycle, and `render_rvalid_o` with `render_rdata_o`=0x5A one cycle later.
- Active display, `render_req_i` high continuously, 1 write pushed:
  - Guard build: forced CPU write in the cycle after the counter reaches 15, with `render_gnt_o`=0 in that cycle.
  - Non-guard build: the write is never issued until `render_req_i` drops.
- `in_vblank_i`=1 with `render_req_i` high and 2 writes queued → 2 CPU grants first, then renderer grants.
- Push 5 writes back-to-back into a depth-4 FIFO while the renderer holds the port → `fifo_full_o` after the 4th push, 5th write dropped, `overflow_o`=1 until reset.
- Assert `rst` with 2 writes queued and a read in flight → the next cycle shows `fifo_empty_o`=1, `render_rvalid_o`=0, and no VRAM write issued.
